fu_exec_lane: RTL and testbench
===============================

Name: fu_exec_lane

Overview:
- Single functional-unit lane on the issue side of the reservation station.
- Consumes one issue packet (issue valid, operands, immediate, ALU type, rd tag, ROB number), executes it, and drives the FU ready flag back to the station.
- Presents its result on a wakeup/forward broadcast port and holds it until the broadcast arbiter acknowledges it.
- Three instances (FU1..FU3) sit between the reservation station and the wakeup bus.

Parameters:
- XLEN, 32, operand/result width
- TAG_W, 6, physical register tag width
- ROB_W, 6, ROB index width
- LS_LATENCY, 2, cycles from issue to result for load/store address generation; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  new instruction issued to this FU this cycle
- issue_is_LS  in  1  load/store instruction
- issue_alusrc  in  1  1 selects issue_imm as operand B, 0 selects issue_rs2_val
- issue_alu_type  in  4  ALU operation code
- issue_rd_tag  in  TAG_W  destination physical tag
- issue_rob_num  in  ROB_W  ROB entry number
- issue_rs1_val  in  XLEN  operand A
- issue_rs2_val  in  XLEN  operand rs2; also store data
- issue_imm  in  XLEN  immediate
- FU_ready  out  1  lane can accept an issue next cycle
- wakeup_valid  out  1  result pending on broadcast
- wakeup_tag  out  TAG_W  rd tag of the result
- wakeup_val  out  XLEN  result value, or effective address for LS
- wakeup_rob_num  out  ROB_W  ROB number of the result
- wakeup_is_LS  out  1  result is a load/store address
- wakeup_store_data  out  XLEN  rs2 value captured for LS; 0 otherwise
- wakeup_ack  in  1  arbiter accepted the broadcast this cycle

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, FU_ready=1, all wakeup_* outputs 0, latency counter 0. Reset asserted mid-EXEC or mid-DONE drops the in-flight op; no broadcast is produced.
- States:
  - IDLE: FU_ready=1.
  - EXEC: counting LS latency.
  - DONE: wakeup_valid=1.
- Issue acceptance: an issue is accepted only in IDLE, with issue_valid=1 and issue_alu_type!=0. Any other issue_valid is ignored with no state change; issue while not ready is a protocol violation.
- Operand B: issue_alusrc ? issue_imm : issue_rs2_val.
- ALU op encodings:
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 SLL, 7 SRL, 8 SRA (shift by B[4:0])
  - 9 SLT (signed), A SLTU
  - B PASS_B (LUI)
  - C..F reserved → result 0
  - Arithmetic wraps modulo 2^XLEN.
- LS ops: wakeup_val = rs1 + imm, regardless of alu_type and alusrc. wakeup_store_data = issue_rs2_val.
- Latency and state transitions:
  - Non-LS, accepted at edge E: IDLE→DONE at E, wakeup_valid high in the cycle after E.
  - LS with LS_LATENCY=1: IDLE→DONE at E.
  - LS otherwise: IDLE→EXEC at E with counter=LS_LATENCY-1. The counter decrements each edge; the lane moves EXEC→DONE at the edge where the counter equals 1. wakeup_valid rises LS_LATENCY cycles after E.
  - Operands and result are registered at acceptance; issue inputs are not used afterwards.
- DONE holds all wakeup_* stable until wakeup_ack=1 is sampled at an edge. Then DONE→IDLE and wakeup_* clear to 0.
- wakeup_ack outside DONE is ignored.
- FU_ready: 1 only in IDLE (registered).

Optional Feature:
- Macro: FU_EARLY_READY_EN.
- Without it: FU_ready is asserted only in IDLE, so back-to-back ops on one lane are spaced by at least one idle cycle.
- With it: FU_ready = IDLE || (DONE && wakeup_ack), combinational from wakeup_ack. An issue_valid sampled at the same edge as the ack is accepted: DONE→DONE (non-LS) or DONE→EXEC (LS), with the new packet's results loaded and no cleared cycle between broadcasts.

Decomposition:
- Shared package: XLEN, TAG_W, ROB_W, ALU op localparams (ALU_NONE..ALU_PASS_B), FU state enum.
- One combinational sub-module, fu_alu: inputs op, a, b; output result.

Test Plan:
- Reset then ADD: issue alu_type=1, rs1=5, rs2=7, alusrc=0, rd_tag=12, rob=3; ack held 1 → next cycle wakeup_valid=1, tag=12, val=12, rob=3; following cycle wakeup_valid=0, FU_ready=1.
- SRA and SLT: SRA with rs1=0x80000000, imm=4, alusrc=1 → 0xF8000000. SLT with -1 vs 1 → 1. SLTU with 0xFFFFFFFF vs 1 → 0.
- LS, LS_LATENCY=2: rs1=0x100, imm=0x20, rs2=0xDEAD, is_LS=1 → FU_ready low in the cycle after issue; wakeup_valid 2 cycles after issue with val=0x120, store_data=0xDEAD, is_LS=1.
- Backpressure: wakeup_ack=0 for 4 cycles → wakeup_* stable and FU_ready=0 throughout; a second issue_valid during this window is ignored. Ack → IDLE.
- Reset mid-EXEC: reset during an LS op with LS_LATENCY=3 → no wakeup_valid ever; FU_ready=1 after reset. Issue with alu_type=0 → ignored, FU_ready stays 1.
- FU_EARLY_READY_EN: in DONE, ack plus a new ADD issued in the same cycle → FU_ready=1 that cycle; the next cycle wakeup_valid=1 with the new tag. Without the macro, the same stimulus drops the issue.

Source files
------------

// File: rtl/fu_exec_lane_pkg.sv
// rtl/fu_exec_lane_pkg.sv - shared widths, ALU op codes and lane state encoding for fu_exec_lane
package fu_exec_lane_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int ROB_W = 6;

    localparam logic [3:0] ALU_NONE   = 4'h0;
    localparam logic [3:0] ALU_ADD    = 4'h1;
    localparam logic [3:0] ALU_SUB    = 4'h2;
    localparam logic [3:0] ALU_AND    = 4'h3;
    localparam logic [3:0] ALU_OR     = 4'h4;
    localparam logic [3:0] ALU_XOR    = 4'h5;
    localparam logic [3:0] ALU_SLL    = 4'h6;
    localparam logic [3:0] ALU_SRL    = 4'h7;
    localparam logic [3:0] ALU_SRA    = 4'h8;
    localparam logic [3:0] ALU_SLT    = 4'h9;
    localparam logic [3:0] ALU_SLTU   = 4'hA;
    localparam logic [3:0] ALU_PASS_B = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } fu_state_e;

endpackage

// File: rtl/fu_exec_lane_alu.sv
// rtl/fu_exec_lane_alu.sv - combinational ALU for one execution lane
module fu_alu
    import fu_exec_lane_pkg::*;
#(
    parameter int W = fu_exec_lane_pkg::XLEN
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result
);

    logic [4:0] shamt;

    always_comb begin
        shamt  = b[4:0];
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = W'($signed(a) >>> shamt);
            ALU_SLT:    result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {{(W-1){1'b0}}, a < b};
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/fu_exec_lane.sv
// rtl/fu_exec_lane.sv - issue-to-wakeup execution lane; FU_EARLY_READY_EN allows re-issue on the ack edge
module fu_exec_lane
    import fu_exec_lane_pkg::*;
#(
    parameter int XLEN       = fu_exec_lane_pkg::XLEN,
    parameter int TAG_W      = fu_exec_lane_pkg::TAG_W,
    parameter int ROB_W      = fu_exec_lane_pkg::ROB_W,
    parameter int LS_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_is_LS,
    input  logic             issue_alusrc,
    input  logic [3:0]       issue_alu_type,
    input  logic [TAG_W-1:0] issue_rd_tag,
    input  logic [ROB_W-1:0] issue_rob_num,
    input  logic [XLEN-1:0]  issue_rs1_val,
    input  logic [XLEN-1:0]  issue_rs2_val,
    input  logic [XLEN-1:0]  issue_imm,
    output logic             FU_ready,
    output logic             wakeup_valid,
    output logic [TAG_W-1:0] wakeup_tag,
    output logic [XLEN-1:0]  wakeup_val,
    output logic [ROB_W-1:0] wakeup_rob_num,
    output logic             wakeup_is_LS,
    output logic [XLEN-1:0]  wakeup_store_data,
    input  logic             wakeup_ack
);

    localparam logic [3:0] LS_INIT  = 4'(LS_LATENCY - 1);
    localparam bit         LS_MULTI = (LS_LATENCY > 1);

    fu_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [ROB_W-1:0] rob_q, rob_d;
    logic [XLEN-1:0]  val_q, val_d;
    logic [XLEN-1:0]  store_q, store_d;
    logic             is_ls_q, is_ls_d;
    logic [XLEN-1:0]  op_b, alu_res;
    logic             ready_c, accept, done;

    fu_alu #(.W(XLEN)) u_alu (
        .op     (issue_alu_type),
        .a      (issue_rs1_val),
        .b      (op_b),
        .result (alu_res)
    );

    assign op_b = issue_alusrc ? issue_imm : issue_rs2_val;

`ifdef FU_EARLY_READY_EN
    assign ready_c = (state_q == S_IDLE) || ((state_q == S_DONE) && wakeup_ack);
`else
    assign ready_c = (state_q == S_IDLE);
`endif

    assign accept = issue_valid && (issue_alu_type != ALU_NONE) && ready_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        rob_d   = rob_q;
        val_d   = val_q;
        store_d = store_q;
        is_ls_d = is_ls_q;
        case (state_q)
            S_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: if (wakeup_ack) state_d = S_IDLE;
            default: ;
        endcase
        // An accepted packet overrides the DONE->IDLE retire when early ready is enabled
        if (accept) begin
            tag_d   = issue_rd_tag;
            rob_d   = issue_rob_num;
            is_ls_d = issue_is_LS;
            val_d   = issue_is_LS ? (issue_rs1_val + issue_imm) : alu_res;
            store_d = issue_is_LS ? issue_rs2_val : '0;
            if (issue_is_LS && LS_MULTI) begin
                state_d = S_EXEC;
                cnt_d   = LS_INIT;
            end else begin
                state_d = S_DONE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            rob_q   <= '0;
            val_q   <= '0;
            store_q <= '0;
            is_ls_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            rob_q   <= rob_d;
            val_q   <= val_d;
            store_q <= store_d;
            is_ls_q <= is_ls_d;
        end
    end

    // Result registers are only visible while the broadcast is pending
    assign done              = (state_q == S_DONE);
    assign FU_ready          = ready_c;
    assign wakeup_valid      = done;
    assign wakeup_tag        = done ? tag_q   : '0;
    assign wakeup_val        = done ? val_q   : '0;
    assign wakeup_rob_num    = done ? rob_q   : '0;
    assign wakeup_is_LS      = done & is_ls_q;
    assign wakeup_store_data = done ? store_q : '0;

endmodule

// File: tb/tb_fu_exec_lane.sv
// tb/tb_fu_exec_lane.sv - scoreboard bench for fu_exec_lane
module tb_fu_exec_lane;

    localparam int LSL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_is_LS, issue_alusrc;
    logic [3:0]  issue_alu_type;
    logic [5:0]  issue_rd_tag, issue_rob_num;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm;
    logic        FU_ready, wakeup_valid, wakeup_is_LS, wakeup_ack;
    logic [5:0]  wakeup_tag, wakeup_rob_num;
    logic [31:0] wakeup_val, wakeup_store_data;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] val;
        logic [5:0]  rob;
        logic        ls;
        logic [31:0] sd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fu_exec_lane #(.XLEN(32), .TAG_W(6), .ROB_W(6), .LS_LATENCY(LSL)) dut (
        .clk               (clk),
        .reset             (reset),
        .issue_valid       (issue_valid),
        .issue_is_LS       (issue_is_LS),
        .issue_alusrc      (issue_alusrc),
        .issue_alu_type    (issue_alu_type),
        .issue_rd_tag      (issue_rd_tag),
        .issue_rob_num     (issue_rob_num),
        .issue_rs1_val     (issue_rs1_val),
        .issue_rs2_val     (issue_rs2_val),
        .issue_imm         (issue_imm),
        .FU_ready          (FU_ready),
        .wakeup_valid      (wakeup_valid),
        .wakeup_tag        (wakeup_tag),
        .wakeup_val        (wakeup_val),
        .wakeup_rob_num    (wakeup_rob_num),
        .wakeup_is_LS      (wakeup_is_LS),
        .wakeup_store_data (wakeup_store_data),
        .wakeup_ack        (wakeup_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return a ^ b;
            4'h6: return a << b[4:0];
            4'h7: return a >> b[4:0];
            4'h8: return 32'($signed(a) >>> b[4:0]);
            4'h9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hA: return (a < b) ? 32'd1 : 32'd0;
            4'hB: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic src, input logic ls,
                         input logic [5:0] tag, input logic [5:0] rob);
        issue_valid    = 1'b1;
        issue_alu_type = op;
        issue_rs1_val  = a;
        issue_rs2_val  = rs2;
        issue_imm      = imm;
        issue_alusrc   = src;
        issue_is_LS    = ls;
        issue_rd_tag   = tag;
        issue_rob_num  = rob;
    endtask

    task automatic push(input logic [5:0] tag, input logic [31:0] val, input logic [5:0] rob,
                        input logic ls, input logic [31:0] sd);
        exp_t e;
        e.tag = tag; e.val = val; e.rob = rob; e.ls = ls; e.sd = sd;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("wk_tag", 64'(wakeup_tag), 64'(e.tag));
            check("wk_val", 64'(wakeup_val), 64'(e.val));
            check("wk_rob", 64'(wakeup_rob_num), 64'(e.rob));
            check("wk_ls", 64'(wakeup_is_LS), 64'(e.ls));
            check("wk_sd", 64'(wakeup_store_data), 64'(e.sd));
        end
    endtask

    // Issue one op, wait (bounded) for its broadcast, compare, then ack it
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic src, input logic ls,
                          input logic [5:0] tag, input logic [5:0] rob,
                          input logic [31:0] expv, input int lat);
        int n;
        @(negedge clk);
        drive(op, a, rs2, imm, src, ls, tag, rob);
        push(tag, expv, rob, ls, ls ? rs2 : 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        check("ready_busy", 64'(FU_ready), 64'd0);
        n = 1;
        while (!wakeup_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("wk_valid", 64'(wakeup_valid), 64'd1);
        pop_check();
        wakeup_ack = 1'b1;
        @(negedge clk);
        wakeup_ack = 1'b0;
        check("retire_valid", 64'(wakeup_valid), 64'd0);
        check("retire_ready", 64'(FU_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        seen;
        logic [3:0]  rop;
        logic [31:0] ra, rb, ri;
        logic        rs, rl;

        reset = 1'b1; wakeup_ack = 1'b0;
        drive(4'h0, 0, 0, 0, 0, 0, 0, 0);
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(FU_ready), 64'd1);
        check("rst_valid", 64'(wakeup_valid), 64'd0);
        check("rst_val", 64'(wakeup_val), 64'd0);
        check("rst_tag", 64'(wakeup_tag), 64'd0);
        reset = 1'b0;

        // ADD with ack held high: one broadcast cycle, then idle
        @(negedge clk);
        drive(4'h1, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 6'd12, 6'd3);
        wakeup_ack = 1'b1;
        push(6'd12, 32'd12, 6'd3, 1'b0, 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        check("add_valid", 64'(wakeup_valid), 64'd1);
        pop_check();
`ifdef FU_EARLY_READY_EN
        check("add_ready_ack", 64'(FU_ready), 64'd1);
`else
        check("add_ready_ack", 64'(FU_ready), 64'd0);
`endif
        @(negedge clk);
        wakeup_ack = 1'b0;
        check("add_after_valid", 64'(wakeup_valid), 64'd0);
        check("add_after_ready", 64'(FU_ready), 64'd1);

        run_op(4'h8, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1'b0, 6'd1, 6'd1, 32'hF800_0000, 1);
        run_op(4'h9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 6'd2, 6'd2, 32'd1, 1);
        run_op(4'hA, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 6'd3, 6'd3, 32'd0, 1);
        run_op(4'h2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 6'd4, 6'd4, 32'hFFFF_FFFE, 1);
        run_op(4'hB, 32'd9, 32'd0, 32'h1234_5000, 1'b1, 1'b0, 6'd5, 6'd5, 32'h1234_5000, 1);
        run_op(4'hC, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 6'd6, 6'd6, 32'd0, 1);
        run_op(4'h1, 32'h100, 32'hDEAD, 32'h20, 1'b0, 1'b1, 6'd7, 6'd7, 32'h120, LSL);

        for (int i = 0; i < 10; i++) begin
            rop = 4'($urandom_range(1, 11));
            ra  = $urandom; rb = $urandom; ri = $urandom;
            rs  = 1'($urandom_range(0, 1));
            rl  = ($urandom_range(0, 3) == 0);
            run_op(rop, ra, rb, ri, rs, rl, 6'(i + 40), 6'(i + 20),
                   rl ? ra + ri : model(rop, ra, rs ? ri : rb), rl ? LSL : 1);
        end

        // Backpressure: result held, second issue ignored
        @(negedge clk);
        drive(4'h1, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 6'd20, 6'd9);
        push(6'd20, 32'd7, 6'd9, 1'b0, 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 64'(wakeup_valid), 64'd1);
            check("bp_tag", 64'(wakeup_tag), 64'd20);
            check("bp_val", 64'(wakeup_val), 64'd7);
            check("bp_ready", 64'(FU_ready), 64'd0);
            if (i == 1) drive(4'h1, 32'd100, 32'd1, 32'd0, 1'b0, 1'b0, 6'd21, 6'd10);
            else issue_valid = 1'b0;
            @(negedge clk);
        end
        issue_valid = 1'b0;
        pop_check();
        wakeup_ack = 1'b1;
        @(negedge clk);
        wakeup_ack = 1'b0;
        check("bp_ready_idle", 64'(FU_ready), 64'd1);
        seen = 1'b0;
        repeat (4) begin
            seen |= wakeup_valid;
            @(negedge clk);
        end
        check("bp_no_ghost", 64'(seen), 64'd0);

        // Reset while an LS op is in EXEC
        drive(4'h1, 32'h200, 32'h55, 32'h8, 1'b0, 1'b1, 6'd30, 6'd11);
        @(negedge clk);
        issue_valid = 1'b0;
        check("rx_ready_busy", 64'(FU_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rx_ready", 64'(FU_ready), 64'd1);
        seen = 1'b0;
        repeat (6) begin
            seen |= wakeup_valid;
            @(negedge clk);
        end
        check("rx_no_wakeup", 64'(seen), 64'd0);

        // alu_type 0 is not an instruction
        drive(4'h0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 6'd31, 6'd12);
        @(negedge clk);
        issue_valid = 1'b0;
        check("nop_ready", 64'(FU_ready), 64'd1);
        seen = 1'b0;
        repeat (3) begin
            seen |= wakeup_valid;
            @(negedge clk);
        end
        check("nop_no_wakeup", 64'(seen), 64'd0);

        // Issue on the ack edge
        drive(4'h1, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 6'd32, 6'd13);
        push(6'd32, 32'd30, 6'd13, 1'b0, 32'd0);
        @(negedge clk);
        check("er_valid1", 64'(wakeup_valid), 64'd1);
        pop_check();
        wakeup_ack = 1'b1;
        drive(4'h1, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 6'd33, 6'd14);
        #1;
`ifdef FU_EARLY_READY_EN
        check("er_ready", 64'(FU_ready), 64'd1);
        push(6'd33, 32'd3, 6'd14, 1'b0, 32'd0);
`else
        check("er_ready", 64'(FU_ready), 64'd0);
`endif
        @(negedge clk);
        issue_valid = 1'b0;
        wakeup_ack  = 1'b0;
`ifdef FU_EARLY_READY_EN
        check("er_valid2", 64'(wakeup_valid), 64'd1);
        pop_check();
        wakeup_ack = 1'b1;
        @(negedge clk);
        wakeup_ack = 1'b0;
`else
        check("er_valid2", 64'(wakeup_valid), 64'd0);
`endif
        check("er_ready_end", 64'(FU_ready), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
